// File: rtl/mipi_data_lane_ctrl.sv
// D-PHY data lane burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero
// -> sync -> payload -> trailer -> LP-11, driven on the PHY byte clock.
module mipi_data_lane_ctrl #(
  parameter int unsigned T_LPX_CYCLES        = 2,
  parameter int unsigned T_HS_PREPARE_CYCLES = 2,
  parameter int unsigned T_HS_ZERO_CYCLES    = 6,
  parameter int unsigned T_HS_TRAIL_CYCLES   = 4,
  parameter int unsigned T_HS_EXIT_CYCLES    = 4
) (
  input  logic       byte_clock_i,
  input  logic       reset_i,
  input  logic       tx_ready_i,
  input  logic       hs_req_i,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  output logic       data_ready_o,
  output logic [7:0] data_o,
  output logic       dout_lp0_o,
  output logic       dout_lp1_o,
  output logic       tristate_data_o,
  output logic       busy_o,
  output logic       underflow_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LPX     = 3'd1;
  localparam logic [2:0] S_PREP    = 3'd2;
  localparam logic [2:0] S_ZERO    = 3'd3;
  localparam logic [2:0] S_SYNC    = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_TRAIL   = 3'd6;
  localparam logic [2:0] S_EXIT    = 3'd7;

  localparam logic [7:0] LPX_LD   = 8'(T_LPX_CYCLES - 1);
  localparam logic [7:0] PREP_LD  = 8'(T_HS_PREPARE_CYCLES - 1);
  localparam logic [7:0] ZERO_LD  = 8'(T_HS_ZERO_CYCLES - 1);
  localparam logic [7:0] TRAIL_LD = 8'(T_HS_TRAIL_CYCLES - 1);
  localparam logic [7:0] EXIT_LD  = 8'(T_HS_EXIT_CYCLES - 1);

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  logic [2:0] state;
  logic [2:0] state_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       last_bit;
  logic       cnt_done;

  assign cnt_done     = (cnt == 8'd0);
  assign data_ready_o = (state == S_PAYLOAD);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (hs_req_i && tx_ready_i) begin
          state_n = S_LPX;
          cnt_n   = LPX_LD;
        end
      end
      S_LPX: begin
        if (cnt_done) begin
          state_n = S_PREP;
          cnt_n   = PREP_LD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_PREP: begin
        if (cnt_done) begin
          state_n = S_ZERO;
          cnt_n   = ZERO_LD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_ZERO: begin
        if (cnt_done) begin
          state_n = S_SYNC;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_SYNC: begin
        state_n = S_PAYLOAD;
        cnt_n   = 8'd0;
      end
      S_PAYLOAD: begin
        // a starved cycle closes the packet just like last_i
        if (!data_valid_i || last_i) begin
          state_n = S_TRAIL;
          cnt_n   = TRAIL_LD;
        end
      end
      S_TRAIL: begin
        if (cnt_done) begin
          state_n = S_EXIT;
          cnt_n   = EXIT_LD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_EXIT: begin
        if (cnt_done) begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge byte_clock_i) begin
    if (reset_i) begin
      state           <= S_IDLE;
      cnt             <= 8'd0;
      last_bit        <= 1'b0;
      data_o          <= 8'h00;
      dout_lp0_o      <= 1'b1;
      dout_lp1_o      <= 1'b1;
      tristate_data_o <= 1'b1;
      busy_o          <= 1'b0;
      underflow_o     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy_o <= (state_n != S_IDLE);
      unique case (state)
        S_IDLE, S_EXIT: begin
          dout_lp0_o      <= 1'b1;
          dout_lp1_o      <= 1'b1;
          tristate_data_o <= 1'b1;
          data_o          <= 8'h00;
        end
        S_LPX: begin
          dout_lp0_o      <= 1'b0;
          dout_lp1_o      <= 1'b1;
          tristate_data_o <= 1'b1;
        end
        S_PREP: begin
          dout_lp0_o      <= 1'b0;
          dout_lp1_o      <= 1'b0;
          tristate_data_o <= 1'b1;
        end
        S_ZERO: begin
          dout_lp0_o      <= 1'b0;
          dout_lp1_o      <= 1'b0;
          tristate_data_o <= 1'b0;
          data_o          <= 8'h00;
        end
        S_SYNC: begin
          dout_lp0_o      <= 1'b0;
          dout_lp1_o      <= 1'b0;
          tristate_data_o <= 1'b0;
          data_o          <= SYNC_BYTE;
        end
        S_PAYLOAD: begin
          dout_lp0_o      <= 1'b0;
          dout_lp1_o      <= 1'b0;
          tristate_data_o <= 1'b0;
          if (data_valid_i) begin
            data_o   <= data_i;
            last_bit <= data_i[7];
          end else begin
            underflow_o <= 1'b1;
          end
        end
        S_TRAIL: begin
          // trailer is the inverse of the final serialised bit
          dout_lp0_o      <= 1'b0;
          dout_lp1_o      <= 1'b0;
          tristate_data_o <= 1'b0;
          data_o          <= {8{~last_bit}};
        end
      endcase
    end
  end

endmodule
